// File: rtl/yoda_pkg.sv
// Shared definitions for the mask application stage.
//   - pixel / ROM address widths
//   - combine-rule encodings carried on the 2-bit mode input
//   - control state encoding used by mask_blend
package yoda_pkg;

   localparam int PIX_W = 12;   // RGB444 {R[11:8],G[7:4],B[3:0]}
   localparam int ROW_W = 7;    // mask_rom row address width (up to 128 lines)
   localparam int COL_W = 8;    // mask_rom column address width (up to 256 pixels)

   localparam logic [1:0] MODE_OVERLAY = 2'd0;  // mask colour unless it is the key colour
   localparam logic [1:0] MODE_AND     = 2'd1;  // bitwise AND of image and mask
   localparam logic [1:0] MODE_BYPASS  = 2'd2;  // image pixel unchanged
   localparam logic [1:0] MODE_MASK    = 2'd3;  // mask colour only

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster position counter for one frame.
//   clk          : clock
//   rst          : synchronous active-high reset
//   i_clear      : force position back to (0,0)
//   i_advance    : step one pixel in raster order
//   o_row/o_col  : current position (registered)
//   o_col_last   : current column is the last of the line
//   o_frame_last : current position is the last pixel of the frame
// The position wraps to (0,0) after the last pixel of the frame.
module raster_counter
   import yoda_pkg::*;
#(
   parameter int IMG_W = 160,
   parameter int IMG_H = 120
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_advance,
   output logic [ROW_W-1:0] o_row,
   output logic [COL_W-1:0] o_col,
   output logic             o_col_last,
   output logic             o_frame_last
);

   localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

   logic [ROW_W-1:0] r_row;
   logic [COL_W-1:0] r_col;
   logic             w_col_last;
   logic             w_frame_last;

   assign w_col_last   = (r_col == COL_MAX);
   assign w_frame_last = w_col_last && (r_row == ROW_MAX);

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_advance) begin
         if (w_col_last) begin
            r_col <= '0;
            r_row <= w_frame_last ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign o_row        = r_row;
   assign o_col        = r_col;
   assign o_col_last   = w_col_last;
   assign o_frame_last = w_frame_last;

endmodule

// File: rtl/mask_blend.sv
// Streaming mask application stage, downstream of mask_rom.
// Takes one raster-ordered RGB444 frame per start, addresses mask_rom with
// the current row/col, and combines each image pixel with the mask colour.
//   clk, rst            : clock, synchronous active-high reset
//   start, mode         : begin a frame (IDLE only), combine rule latched at start
//   in_valid/in_ready   : image pixel handshake, in_pixel data
//   rom_row/rom_col     : mask address (registered counters)
//   rom_data            : mask colour, combinational from the address
//   out_valid/out_ready : output handshake; out_pixel, out_sof/eol/eof
//   busy                : frame in progress (RUN or DRAIN)
//   done                : one-cycle pulse once the last pixel has left
module mask_blend
   import yoda_pkg::*;
#(
   parameter int               IMG_W     = 160,
   parameter int               IMG_H     = 120,
   parameter logic [PIX_W-1:0] KEY_COLOR = 12'h000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pixel,
   output logic [ROW_W-1:0] rom_row,
   output logic [COL_W-1:0] rom_col,
   input  logic [PIX_W-1:0] rom_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_pixel,
   output logic             out_sof,
   output logic             out_eol,
   output logic             out_eof,
   output logic             busy,
   output logic             done
);

   state_t           r_state;
   state_t           w_state_next;
   logic [1:0]       r_mode;
   logic             r_out_valid;
   logic [PIX_W-1:0] r_out_pixel;
   logic             r_sof;
   logic             r_eol;
   logic             r_eof;
   logic             r_done;
   logic             w_done_next;
   logic             w_start_frame;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_col_last;
   logic             w_frame_last;
   logic [ROW_W-1:0] w_row;
   logic [COL_W-1:0] w_col;

   function automatic logic [PIX_W-1:0] combine(
      input logic [PIX_W-1:0] pix,
      input logic [PIX_W-1:0] mask,
      input logic [1:0]       m
   );
      case (m)
         MODE_OVERLAY: combine = (mask == KEY_COLOR) ? pix : mask;
         MODE_AND:     combine = pix & mask;
         MODE_BYPASS:  combine = pix;
         default:      combine = mask;
      endcase
   endfunction

   raster_counter #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) u_raster_counter (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (w_start_frame),
      .i_advance    (w_accept),
      .o_row        (w_row),
      .o_col        (w_col),
      .o_col_last   (w_col_last),
      .o_frame_last (w_frame_last)
   );

   // The single output register may take a new pixel when it is empty or
   // being drained this same cycle.
   assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && w_in_ready;

   always_comb begin
      w_state_next  = r_state;
      w_done_next   = 1'b0;
      w_start_frame = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next  = ST_RUN;
               w_start_frame = 1'b1;
            end
         end
         ST_RUN: begin
            if (w_accept && w_frame_last) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Finished once the last pixel is gone or leaves this cycle.
            if (!r_out_valid || out_ready) begin
               w_state_next = ST_IDLE;
               w_done_next  = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= w_done_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode <= MODE_OVERLAY;
      end else if (w_start_frame) begin
         r_mode <= mode;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_pixel <= '0;
         r_sof       <= 1'b0;
         r_eol       <= 1'b0;
         r_eof       <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_pixel <= combine(in_pixel, rom_data, r_mode);
         r_sof       <= (w_row == '0) && (w_col == '0);
         r_eol       <= w_col_last;
         r_eof       <= w_frame_last;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = w_in_ready;
   assign rom_row   = w_row;
   assign rom_col   = w_col;
   assign out_valid = r_out_valid;
   assign out_pixel = r_out_pixel;
   assign out_sof   = r_sof;
   assign out_eol   = r_eol;
   assign out_eof   = r_eof;
   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;

endmodule

// File: tb/tb_mask_blend.sv
// Bench for mask_blend on a 4x2 image. A transaction-level model predicts
// every output pixel from the combine rules and the mask table, keeps the
// expected output stream in a queue, and is compared each cycle.
module tb_mask_blend;

   localparam int W    = 4;
   localparam int H    = 2;
   localparam int NPIX = W * H;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  mode;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_pixel;
   logic [6:0]  rom_row;
   logic [7:0]  rom_col;
   logic [11:0] rom_data;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_pixel;
   logic        out_sof;
   logic        out_eol;
   logic        out_eof;
   logic        busy;
   logic        done;

   mask_blend #(
      .IMG_W     (W),
      .IMG_H     (H),
      .KEY_COLOR (12'h000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pixel  (in_pixel),
      .rom_row   (rom_row),
      .rom_col   (rom_col),
      .rom_data  (rom_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pixel (out_pixel),
      .out_sof   (out_sof),
      .out_eol   (out_eol),
      .out_eof   (out_eof),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mask ROM model: combinational lookup of a per-frame table.
   logic [11:0] mask_tab [NPIX];
   int          rom_idx;
   always_comb begin
      rom_idx  = int'(rom_row) * W + int'(rom_col);
      rom_data = 12'h000;
      if (rom_idx < NPIX) rom_data = mask_tab[rom_idx];
   end

   typedef struct packed {
      logic [11:0] pix;
      logic        sof;
      logic        eol;
      logic        eof;
   } exp_t;

   exp_t       exp_q[$];
   int         acc_idx;
   logic [1:0] m_mode;
   bit         frame_open;
   bit         done_due;
   bit         saw_done;
   int         n_checks;
   int         n_errors;
   int         n_out;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, want);
      end
   endtask

   function automatic logic [11:0] ref_combine(input logic [11:0] pix, input logic [11:0] mask,
                                               input logic [1:0] m);
      case (m)
         2'd0:    return (mask == 12'h000) ? pix : mask;
         2'd1:    return pix & mask;
         2'd2:    return pix;
         default: return mask;
      endcase
   endfunction

   // Called once per cycle, after inputs settle and before the next rising edge.
   task automatic sample();
      exp_t e;
      bit   exp_valid;
      bit   exp_ready;
      int   pos;
      check("done", 32'(done), 32'(done_due));
      if (done_due) begin
         frame_open = 0;
         done_due   = 0;
         saw_done   = 1;
      end
      check("busy", 32'(busy), 32'(frame_open));
      exp_valid = (exp_q.size() > 0);
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      if (out_valid && exp_valid) begin
         e = exp_q[0];
         check("out_pixel", 32'(out_pixel), 32'(e.pix));
         check("out_sof", 32'(out_sof), 32'(e.sof));
         check("out_eol", 32'(out_eol), 32'(e.eol));
         check("out_eof", 32'(out_eof), 32'(e.eof));
      end
      exp_ready = frame_open && (acc_idx < NPIX) && (!exp_valid || out_ready);
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      pos = (acc_idx < NPIX) ? acc_idx : 0;
      check("rom_row", 32'(rom_row), 32'(pos / W));
      check("rom_col", 32'(rom_col), 32'(pos % W));
      if (out_valid && out_ready && exp_valid) begin
         $display("out %0d pix=%03h sof=%0d eol=%0d eof=%0d", n_out, out_pixel, out_sof, out_eol,
                  out_eof);
         n_out++;
         void'(exp_q.pop_front());
         if (acc_idx == NPIX && exp_q.size() == 0) done_due = 1;
      end
      if (in_valid && exp_ready) begin
         e.pix = ref_combine(in_pixel, mask_tab[acc_idx], m_mode);
         e.sof = (acc_idx == 0);
         e.eol = ((acc_idx % W) == W - 1);
         e.eof = (acc_idx == NPIX - 1);
         exp_q.push_back(e);
         acc_idx++;
      end
      if (start && !frame_open) begin
         frame_open = 1;
         m_mode     = mode;
         acc_idx    = 0;
      end
   endtask

   // pix_sel: 0 sequential 001.., 1 fixed pix_fix, 2 random
   task automatic run_frame(input logic [1:0] m, input int pix_sel, input logic [11:0] pix_fix,
                            input bit rnd, input bit stall, input bit check_rate);
      int cyc;
      int last_acc_cyc;
      saw_done     = 0;
      last_acc_cyc = -1;
      @(negedge clk);
      start     = 1'b1;
      mode      = m;
      in_valid  = 1'($urandom_range(0, 1));
      in_pixel  = 12'($urandom);
      out_ready = 1'b1;
      #1 sample();
      cyc = 0;
      while (!saw_done && cyc < 200) begin
         @(negedge clk);
         start     = rnd && !done_due && ($urandom_range(0, 3) == 0);
         mode      = rnd ? 2'($urandom_range(0, 3)) : ~m;
         in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(stall && cyc >= 2 && cyc <= 4);
         case (pix_sel)
            0:       in_pixel = 12'(acc_idx + 1);
            1:       in_pixel = pix_fix;
            default: in_pixel = 12'($urandom);
         endcase
         #1 sample();
         if (acc_idx == NPIX && last_acc_cyc < 0) last_acc_cyc = cyc;
         cyc++;
      end
      if (!saw_done) check("frame_timeout", 32'(saw_done), 32'd1);
      if (check_rate) check("full_rate", 32'(last_acc_cyc), 32'(NPIX - 1));
      $display("frame mode=%0d done after %0d cycles", m, cyc);
   endtask

   task automatic check_reset_values();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_pixel", 32'(out_pixel), 32'd0);
      check("rst_flags", 32'({out_sof, out_eol, out_eof}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_rom_addr", 32'({rom_row, rom_col}), 32'd0);
   endtask

   task automatic clear_model();
      exp_q.delete();
      acc_idx    = 0;
      frame_open = 0;
      done_due   = 0;
      m_mode     = 2'd0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      n_out    = 0;
      clear_model();
      for (int i = 0; i < NPIX; i++) mask_tab[i] = 12'($urandom);
      rst       = 1'b1;
      start     = 1'b0;
      mode      = 2'd0;
      in_valid  = 1'b0;
      in_pixel  = 12'h000;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1 check_reset_values();

      // Bypass, sequential pixels, full rate.
      run_frame(2'd2, 0, 12'h000, 0, 0, 1);

      // Overlay: key colour at column 0 lets the image through.
      for (int i = 0; i < NPIX; i++) mask_tab[i] = ((i % W) == 0) ? 12'h000 : 12'hF00;
      run_frame(2'd0, 1, 12'h0AB, 0, 0, 1);

      // AND mode.
      for (int i = 0; i < NPIX; i++) mask_tab[i] = 12'h5A3;
      run_frame(2'd1, 1, 12'hFFF, 0, 0, 1);
      run_frame(2'd1, 1, 12'h0F0, 0, 0, 1);

      // Three cycles of output backpressure mid-line.
      for (int i = 0; i < NPIX; i++) mask_tab[i] = 12'($urandom);
      run_frame(2'd2, 0, 12'h000, 0, 1, 0);

      // Randomized handshakes, stray start pulses and mode changes mid-frame.
      for (int f = 0; f < 12; f++) begin
         for (int i = 0; i < NPIX; i++)
            mask_tab[i] = ($urandom_range(0, 2) == 0) ? 12'h000 : 12'($urandom);
         run_frame(2'($urandom_range(0, 3)), 2, 12'h000, 1, 0, 0);
      end

      // Reset after three accepted pixels aborts the frame.
      @(negedge clk);
      start     = 1'b1;
      mode      = 2'd3;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1 sample();
      for (int c = 0; c < 20 && acc_idx < 3; c++) begin
         @(negedge clk);
         start    = 1'b0;
         in_pixel = 12'($urandom);
         #1 sample();
      end
      check("pre_reset_accepts", 32'(acc_idx), 32'd3);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      #1 check_reset_values();
      clear_model();
      @(negedge clk);
      #1 sample();
      run_frame(2'd2, 0, 12'h000, 0, 0, 1);

      check("frames_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mask_blend.md
# mask_blend

Streaming mask-application stage directly downstream of `mask_rom`. Accepts a raster-ordered 12-bit RGB444 image stream, drives `mask_rom` with the matching row/col address, and combines each image pixel with the returned mask colour. Emits a masked pixel stream with frame/line markers. One frame is processed per `start`; throughput is one pixel per clock when unstalled.

## Interface
- `IMG_W`, 160, pixels per line (≤256; sets `rom_col` range)
- `IMG_H`, 120, lines per frame (≤128; sets `rom_row` range)
- `KEY_COLOR`, 12'h000, mask colour treated as transparent in overlay mode
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin one frame; sampled only in IDLE
- `mode`  in  2  combine rule; latched on accepted `start`
- `in_valid`  in  1  image pixel valid
- `in_ready`  out  1  stage accepts pixel this cycle
- `in_pixel`  in  12  image pixel {R[11:8],G[7:4],B[3:0]}
- `rom_row`  out  7  mask row address to `mask_rom`
- `rom_col`  out  8  mask column address to `mask_rom`
- `rom_data`  in  12  mask colour from `mask_rom`, combinational, same cycle
- `out_valid`  out  1  output pixel valid
- `out_ready`  in  1  downstream accepts output
- `out_pixel`  out  12  masked pixel
- `out_sof`, `out_eol`, `out_eof`  out  1 each  first pixel of frame / last of line / last of frame, qualified by `out_valid`
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `start`=1 → RUN; `row_cnt`, `col_cnt` ← 0; `mode_q` ← `mode`. `start` ignored outside IDLE.
- RUN: `in_ready` = !`out_valid` | `out_ready`. Accept = `in_valid` & `in_ready`.
- `rom_row` = `row_cnt`, `rom_col` = `col_cnt` (registered counters, driven directly).
- On accept: `out_pixel` ← f(`in_pixel`, `rom_data`, `mode_q`); `out_valid` ← 1; `out_sof` ← (row=0 & col=0); `out_eol` ← (col=IMG_W-1); `out_eof` ← (row=IMG_H-1 & col=IMG_W-1).
- Counter advance on accept: col=IMG_W-1 → col←0, row←row+1; else col←col+1. Last pixel (row=IMG_H-1, col=IMG_W-1) → counters ← 0, state → DRAIN.
- Output hold: `out_valid` & !`out_ready` → all out_* hold. `out_ready` & no accept → `out_valid` ← 0.
- DRAIN: `in_ready`=0. When `out_valid`=0, or `out_valid` & `out_ready` → `done` ← 1 for one cycle, state → IDLE.
- Combine rule f:
  - 0 overlay: `rom_data`==KEY_COLOR ? `in_pixel` : `rom_data`
  - 1 AND: `in_pixel` & `rom_data`
  - 2 bypass: `in_pixel`
  - 3 mask only: `rom_data`
- IDLE: `in_ready`=0; input data ignored.

## Timing
- Reset values: state IDLE, counters 0, `in_ready`=0, `out_valid`=0, `out_pixel`=0, all flags 0, `busy`=0, `done`=0, `rom_row`=0, `rom_col`=0. Reset mid-frame aborts immediately: no `done`, no output flush.
- Latency: accepted pixel appears on `out_*` the next cycle.
- `in_ready` is combinational from `out_valid`/`out_ready`/state; `out_*` are registered.
- Full-rate: `out_ready`=1 and `in_valid`=1 give one pixel/cycle; IMG_W·IMG_H accepts in RUN.
- `start` → first possible accept: 1 cycle (RUN entered on next edge).
- Last output handshake → `done` on next edge; `start` accepted the cycle after `done`.

## Structure
- Shared package `yoda_pkg`: mode encodings (MODE_OVERLAY=0, MODE_AND=1, MODE_BYPASS=2, MODE_MASK=3), state enum, pixel width 12, address widths 7/8.
- Sub-module `raster_counter` (row/col counters with wrap and last flags, parameterised by IMG_W/IMG_H); combine function and FSM in the top.

## Test plan
- Reset then IMG_W=4, IMG_H=2, mode 2, `out_ready`=1, pixels 12'h001…12'h008 → outputs 001…008 one cycle later, `out_sof` on 001, `out_eol` on 004/008, `out_eof` on 008, `done` one cycle after 008 handshake.
- Mode 0, `rom_data`=12'h000 at col 0, 12'hF00 elsewhere, `in_pixel`=12'h0AB → outputs 0AB at col 0, F00 at others; `rom_row`/`rom_col` step (0,0),(0,1)…(1,3).
- Mode 1, `in_pixel`=12'hFFF, `rom_data`=12'h5A3 → 5A3; `in_pixel`=12'h0F0 → 0A0.
- Backpressure: `out_ready`=0 for 3 cycles mid-line → `in_ready`=0, `out_pixel` and counters hold; release → stream resumes, no pixel lost or duplicated.
- `start` pulsed during RUN and `mode` changed mid-frame → no effect on counters or combine rule.
- `rst` asserted after 3 pixels → next cycle all outputs at reset values, no `done`; new `start` begins at (0,0) with `out_sof`.
